// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single memory bus between the instruction cache and the data
//   cache. One request is forwarded per cycle. The memory's acceptance tag goes
//   back to whichever side was granted. An owner table remembers which cache
//   issued each outstanding load tag, so that returning data reaches the right
//   cache.
//
// Ports
//   clock, reset              rising-edge clock, asynchronous active-high reset
//   Icache2mem_command/addr   icache request (loads only)
//   Dcache2mem_command/addr/data  dcache request (loads and stores)
//   mem2proc_response         memory acceptance tag for this cycle (0 = rejected)
//   mem2proc_data/tag         returning load data and its tag (tag 0 = none)
//   proc2mem_command/addr/data    forwarded request
//   Imem2proc_response/data/tag   icache view of response and returns
//   Dmem2proc_response/data/tag   dcache view of response and returns
//   arb_idle                  high when no load tag is outstanding
//
// Parameter
//   STARVE_LIMIT  consecutive icache-not-accepted cycles (1..15) after which
//                 the icache wins a contested cycle
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  Icache2mem_command,
  input  logic [63:0] Icache2mem_addr,
  input  logic [1:0]  Dcache2mem_command,
  input  logic [63:0] Dcache2mem_addr,
  input  logic [63:0] Dcache2mem_data,
  input  logic [3:0]  mem2proc_response,
  input  logic [63:0] mem2proc_data,
  input  logic [3:0]  mem2proc_tag,
  output logic [1:0]  proc2mem_command,
  output logic [63:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,
  output logic [3:0]  Imem2proc_response,
  output logic [63:0] Imem2proc_data,
  output logic [3:0]  Imem2proc_tag,
  output logic [3:0]  Dmem2proc_response,
  output logic [63:0] Dmem2proc_data,
  output logic [3:0]  Dmem2proc_tag,
  output logic        arb_idle
);

  localparam logic [1:0] BUS_LOAD      = 2'd1;
  localparam logic [3:0] STARVE_THRESH = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_I,
    GRANT_D
  } grant_e;

  // Owner table for tags 1..15; owner bit 1 means the dcache issued the load.
  logic [15:1] r_valid;
  logic [15:1] r_owner;
  logic [3:0]  r_waitCnt;

  grant_e      w_grant;
  logic        w_iReq;
  logic        w_dReq;
  logic [15:0] w_validExt;
  logic [15:0] w_ownerExt;
  logic        w_retHit;
  logic        w_retToD;
  logic        w_capture;

  assign w_iReq = (Icache2mem_command != 2'd0);
  assign w_dReq = (Dcache2mem_command != 2'd0);

  // Tag 0 means "no tag"; padding bit 0 with zero makes a lookup of tag 0
  // always miss without a separate compare.
  assign w_validExt = {r_valid, 1'b0};
  assign w_ownerExt = {r_owner, 1'b0};

  assign w_retHit  = w_validExt[mem2proc_tag];
  assign w_retToD  = w_retHit && w_ownerExt[mem2proc_tag];
  assign w_capture = (mem2proc_response != 4'd0) && (proc2mem_command == BUS_LOAD);

  assign arb_idle = ~|r_valid;

  // The dcache wins contested cycles unless the icache has been waiting long
  // enough to be considered starved.
  always_comb begin
    w_grant = GRANT_NONE;
    if (w_iReq && w_dReq) begin
      w_grant = (r_waitCnt >= STARVE_THRESH) ? GRANT_I : GRANT_D;
    end else if (w_iReq) begin
      w_grant = GRANT_I;
    end else if (w_dReq) begin
      w_grant = GRANT_D;
    end
  end

  // Forward the granted request and steer the acceptance tag back to it.
  always_comb begin
    proc2mem_command   = 2'd0;
    proc2mem_addr      = 64'd0;
    proc2mem_data      = 64'd0;
    Imem2proc_response = 4'd0;
    Dmem2proc_response = 4'd0;
    case (w_grant)
      GRANT_I: begin
        proc2mem_command   = Icache2mem_command;
        proc2mem_addr      = Icache2mem_addr;
        Imem2proc_response = mem2proc_response;
      end
      GRANT_D: begin
        proc2mem_command   = Dcache2mem_command;
        proc2mem_addr      = Dcache2mem_addr;
        proc2mem_data      = Dcache2mem_data;
        Dmem2proc_response = mem2proc_response;
      end
      default: ;
    endcase
  end

  // Returns are looked up in the table as it stood before this edge, so a
  // stray tag never reaches either cache.
  always_comb begin
    Imem2proc_tag  = 4'd0;
    Imem2proc_data = 64'd0;
    Dmem2proc_tag  = 4'd0;
    Dmem2proc_data = 64'd0;
    if (w_retHit) begin
      if (w_retToD) begin
        Dmem2proc_tag  = mem2proc_tag;
        Dmem2proc_data = mem2proc_data;
      end else begin
        Imem2proc_tag  = mem2proc_tag;
        Imem2proc_data = mem2proc_data;
      end
    end
  end

  // Table and starvation counter. The capture is written after the return
  // clear so that a same-tag capture leaves the entry valid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid   <= '0;
      r_owner   <= '0;
      r_waitCnt <= 4'd0;
    end else begin
      if (w_retHit) begin
        r_valid[mem2proc_tag] <= 1'b0;
      end
      if (w_capture) begin
        r_valid[mem2proc_response] <= 1'b1;
        r_owner[mem2proc_response] <= (w_grant == GRANT_D);
      end
      if (!w_iReq || ((w_grant == GRANT_I) && (mem2proc_response != 4'd0))) begin
        r_waitCnt <= 4'd0;
      end else if (r_waitCnt != 4'd15) begin
        r_waitCnt <= r_waitCnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Drives mem_arbiter cycle by cycle. Each cycle's expected outputs come from
//   a small reference model of the arbiter, are queued when the stimulus is
//   applied and are compared on the falling edge when the DUT presents them.
module tb_mem_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  Icache2mem_command = '0;
  logic [63:0] Icache2mem_addr = '0;
  logic [1:0]  Dcache2mem_command = '0;
  logic [63:0] Dcache2mem_addr = '0;
  logic [63:0] Dcache2mem_data = '0;
  logic [3:0]  mem2proc_response = '0;
  logic [63:0] mem2proc_data = '0;
  logic [3:0]  mem2proc_tag = '0;
  logic [1:0]  proc2mem_command;
  logic [63:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  Imem2proc_response;
  logic [63:0] Imem2proc_data;
  logic [3:0]  Imem2proc_tag;
  logic [3:0]  Dmem2proc_response;
  logic [63:0] Dmem2proc_data;
  logic [3:0]  Dmem2proc_tag;
  logic        arb_idle;

  mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clock              (clock),
    .reset              (reset),
    .Icache2mem_command (Icache2mem_command),
    .Icache2mem_addr    (Icache2mem_addr),
    .Dcache2mem_command (Dcache2mem_command),
    .Dcache2mem_addr    (Dcache2mem_addr),
    .Dcache2mem_data    (Dcache2mem_data),
    .mem2proc_response  (mem2proc_response),
    .mem2proc_data      (mem2proc_data),
    .mem2proc_tag       (mem2proc_tag),
    .proc2mem_command   (proc2mem_command),
    .proc2mem_addr      (proc2mem_addr),
    .proc2mem_data      (proc2mem_data),
    .Imem2proc_response (Imem2proc_response),
    .Imem2proc_data     (Imem2proc_data),
    .Imem2proc_tag      (Imem2proc_tag),
    .Dmem2proc_response (Dmem2proc_response),
    .Dmem2proc_data     (Dmem2proc_data),
    .Dmem2proc_tag      (Dmem2proc_tag),
    .arb_idle           (arb_idle)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  pCmd;
    logic [63:0] pAddr;
    logic [63:0] pData;
    logic [3:0]  iResp;
    logic [63:0] iData;
    logic [3:0]  iTag;
    logic [3:0]  dResp;
    logic [63:0] dData;
    logic [3:0]  dTag;
    logic        idle;
  } expect_t;

  expect_t sbQueue[$];

  int assertCount = 0;
  int failCount = 0;

  // Reference model state
  logic mValid[16];
  logic mOwnerD[16];
  int   mWait;

  task automatic checkOutput(input string tagName, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t",
               tagName, observed, expected, $time);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < 16; i++) begin
      mValid[i]  = 1'b0;
      mOwnerD[i] = 1'b0;
    end
    mWait = 0;
  endtask

  task automatic compareCycle();
    expect_t e;
    checkOutput("queueNotEmpty", 64'(sbQueue.size() != 0), 64'd1);
    if (sbQueue.size() != 0) begin
      e = sbQueue.pop_front();
      checkOutput("proc2mem_command", 64'(proc2mem_command), 64'(e.pCmd));
      checkOutput("proc2mem_addr", proc2mem_addr, e.pAddr);
      checkOutput("proc2mem_data", proc2mem_data, e.pData);
      checkOutput("Imem2proc_response", 64'(Imem2proc_response), 64'(e.iResp));
      checkOutput("Imem2proc_data", Imem2proc_data, e.iData);
      checkOutput("Imem2proc_tag", 64'(Imem2proc_tag), 64'(e.iTag));
      checkOutput("Dmem2proc_response", 64'(Dmem2proc_response), 64'(e.dResp));
      checkOutput("Dmem2proc_data", Dmem2proc_data, e.dData);
      checkOutput("Dmem2proc_tag", 64'(Dmem2proc_tag), 64'(e.dTag));
      checkOutput("arb_idle", 64'(arb_idle), 64'(e.idle));
    end
  endtask

  // Drives one cycle of stimulus just after the rising edge, queues the
  // model's prediction, compares on the falling edge and then advances the
  // model to its post-edge state. Returns at the falling edge so callers can
  // add directed checks on the same cycle.
  task automatic applyStimulus(input logic [1:0] iCmd, input logic [63:0] iAddr,
                               input logic [1:0] dCmd, input logic [63:0] dAddr,
                               input logic [63:0] dData, input logic [3:0] resp,
                               input logic [3:0] rTag, input logic [63:0] rData);
    expect_t e;
    int      grant;
    logic    retOk;
    logic    anyValid;
    @(posedge clock);
    #1;
    Icache2mem_command = iCmd;
    Icache2mem_addr    = iAddr;
    Dcache2mem_command = dCmd;
    Dcache2mem_addr    = dAddr;
    Dcache2mem_data    = dData;
    mem2proc_response  = resp;
    mem2proc_tag       = rTag;
    mem2proc_data      = rData;

    if (iCmd != 0 && dCmd != 0) grant = (mWait >= STARVE_LIMIT) ? 1 : 2;
    else if (iCmd != 0)         grant = 1;
    else if (dCmd != 0)         grant = 2;
    else                        grant = 0;

    e.pCmd  = (grant == 1) ? iCmd  : (grant == 2) ? dCmd  : 2'd0;
    e.pAddr = (grant == 1) ? iAddr : (grant == 2) ? dAddr : 64'd0;
    e.pData = (grant == 2) ? dData : 64'd0;
    e.iResp = (grant == 1) ? resp : 4'd0;
    e.dResp = (grant == 2) ? resp : 4'd0;
    retOk   = (rTag != 0) && mValid[rTag];
    e.iTag  = (retOk && !mOwnerD[rTag]) ? rTag  : 4'd0;
    e.iData = (retOk && !mOwnerD[rTag]) ? rData : 64'd0;
    e.dTag  = (retOk && mOwnerD[rTag])  ? rTag  : 4'd0;
    e.dData = (retOk && mOwnerD[rTag])  ? rData : 64'd0;
    anyValid = 1'b0;
    for (int i = 1; i < 16; i++) anyValid |= mValid[i];
    e.idle = !anyValid;
    sbQueue.push_back(e);

    @(negedge clock);
    compareCycle();

    if (retOk) mValid[rTag] = 1'b0;
    if (resp != 0 && e.pCmd == 2'd1) begin
      mValid[resp]  = 1'b1;
      mOwnerD[resp] = (grant == 2);
    end
    if (iCmd == 0 || (grant == 1 && resp != 0)) mWait = 0;
    else if (mWait < 15) mWait++;
  endtask

  task automatic idleCycle();
    applyStimulus(2'd0, 64'd0, 2'd0, 64'd0, 64'd0, 4'd0, 4'd0, 64'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetModel();
    $display("[TB] starting mem_arbiter test");

    // Reset state with all inputs low
    #3;
    checkOutput("resetIdle", 64'(arb_idle), 64'd1);
    checkOutput("resetProcCmd", 64'(proc2mem_command), 64'd0);
    checkOutput("resetDTag", 64'(Dmem2proc_tag), 64'd0);
    @(posedge clock);
    #2;
    reset = 1'b0;

    // Contested load: dcache wins, tag 3 goes to the dcache only
    applyStimulus(2'd1, 64'h1000, 2'd1, 64'h2000, 64'h0, 4'd3, 4'd0, 64'd0);
    checkOutput("contestDResp", 64'(Dmem2proc_response), 64'd3);
    checkOutput("contestIResp", 64'(Imem2proc_response), 64'd0);
    idleCycle();
    checkOutput("contestIdleDrop", 64'(arb_idle), 64'd0);
    applyStimulus(2'd0, 64'd0, 2'd0, 64'd0, 64'd0, 4'd0, 4'd3, 64'h33);
    checkOutput("contestReturnD", 64'(Dmem2proc_tag), 64'd3);

    // Starvation: dcache always accepted, icache wins the fifth cycle
    for (int c = 0; c < 6; c++) begin
      applyStimulus(2'd1, 64'h1100 + 64'(c), 2'd1, 64'h2100 + 64'(c), 64'h0,
                    4'(8 + c), 4'd0, 64'd0);
      if (c == 4) begin
        checkOutput("starveIResp", 64'(Imem2proc_response), 64'd12);
        checkOutput("starveProcAddr", proc2mem_addr, 64'h1104);
      end
      if (c == 5) begin
        checkOutput("starveClearedDResp", 64'(Dmem2proc_response), 64'd13);
      end
    end
    for (int t = 8; t < 14; t++) begin
      applyStimulus(2'd0, 64'd0, 2'd0, 64'd0, 64'd0, 4'd0, 4'(t), 64'(t * 16));
    end

    // Icache load on tag 5, returned six cycles later
    applyStimulus(2'd1, 64'h3000, 2'd0, 64'd0, 64'd0, 4'd5, 4'd0, 64'd0);
    for (int c = 0; c < 5; c++) idleCycle();
    applyStimulus(2'd0, 64'd0, 2'd0, 64'd0, 64'd0, 4'd0, 4'd5, 64'hDEAD);
    checkOutput("iReturnTag", 64'(Imem2proc_tag), 64'd5);
    checkOutput("iReturnData", Imem2proc_data, 64'hDEAD);
    checkOutput("iReturnDTag", 64'(Dmem2proc_tag), 64'd0);
    idleCycle();
    checkOutput("iReturnIdle", 64'(arb_idle), 64'd1);

    // Dcache store on tag 7 never allocates; its return is dropped
    applyStimulus(2'd0, 64'd0, 2'd2, 64'h4000, 64'hCAFE, 4'd7, 4'd0, 64'd0);
    checkOutput("storeData", proc2mem_data, 64'hCAFE);
    applyStimulus(2'd0, 64'd0, 2'd0, 64'd0, 64'd0, 4'd0, 4'd7, 64'h77);
    checkOutput("storeStrayDTag", 64'(Dmem2proc_tag), 64'd0);
    checkOutput("storeStrayITag", 64'(Imem2proc_tag), 64'd0);
    checkOutput("storeIdle", 64'(arb_idle), 64'd1);

    // Outstanding tags 2 (D) and 9 (I), then an asynchronous reset pulse
    applyStimulus(2'd0, 64'd0, 2'd1, 64'h5000, 64'd0, 4'd2, 4'd0, 64'd0);
    applyStimulus(2'd1, 64'h6000, 2'd0, 64'd0, 64'd0, 4'd9, 4'd0, 64'd0);
    @(posedge clock);
    #2;
    Icache2mem_command = 2'd0;
    Dcache2mem_command = 2'd0;
    mem2proc_response  = 4'd0;
    checkOutput("preResetBusy", 64'(arb_idle), 64'd0);
    reset = 1'b1;
    #1;
    checkOutput("midResetIdle", 64'(arb_idle), 64'd1);
    #1;
    reset = 1'b0;
    resetModel();
    applyStimulus(2'd0, 64'd0, 2'd0, 64'd0, 64'd0, 4'd0, 4'd2, 64'h22);
    checkOutput("postResetStrayD", 64'(Dmem2proc_tag), 64'd0);

    // Return of tag 4 (D) alongside a new icache capture of tag 6
    applyStimulus(2'd0, 64'd0, 2'd1, 64'h7000, 64'd0, 4'd4, 4'd0, 64'd0);
    applyStimulus(2'd1, 64'h7100, 2'd0, 64'd0, 64'd0, 4'd6, 4'd4, 64'h44);
    checkOutput("overlapDTag", 64'(Dmem2proc_tag), 64'd4);
    idleCycle();
    checkOutput("overlapBusy", 64'(arb_idle), 64'd0);
    applyStimulus(2'd0, 64'd0, 2'd0, 64'd0, 64'd0, 4'd0, 4'd6, 64'h66);
    checkOutput("overlapOwnerI", 64'(Imem2proc_tag), 64'd6);

    // Same-tag return and capture: return is stray, capture sticks
    applyStimulus(2'd0, 64'd0, 2'd1, 64'h8000, 64'd0, 4'd10, 4'd10, 64'hAA);
    checkOutput("sameTagStray", 64'(Dmem2proc_tag), 64'd0);
    applyStimulus(2'd0, 64'd0, 2'd0, 64'd0, 64'd0, 4'd0, 4'd10, 64'hAB);
    checkOutput("sameTagLater", 64'(Dmem2proc_tag), 64'd10);

    // Random traffic checked against the model
    for (int c = 0; c < 60; c++) begin
      applyStimulus(2'($urandom_range(0, 1)), {32'd0, $urandom()},
                    2'($urandom_range(0, 2)), {32'd0, $urandom()},
                    {$urandom(), $urandom()},
                    ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
                    4'($urandom_range(0, 15)), {$urandom(), $urandom()});
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
